// File: rtl/z16_fetch_unit.sv
// z16_fetch_unit: PC register and IF/ID pipeline register for the Z16 core.
// Priority per edge is redirect, then stall, then advance; all outputs to decode are registered.
`default_nettype none

module z16_fetch_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_br_taken,
  input  logic [15:0] i_br_target,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic [15:0] o_id_instr,
  output logic [15:0] o_id_pc,
  output logic [15:0] o_id_pc_plus2,
  output logic        o_id_valid,
  output logic [15:0] o_fetch_count
);

  logic [15:0] pc_q,          pc_d;
  logic [15:0] id_instr_q,    id_instr_d;
  logic [15:0] id_pc_q,       id_pc_d;
  logic [15:0] id_pc_plus2_q, id_pc_plus2_d;
  logic        id_valid_q,    id_valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] pc_plus2;

  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus2_d = id_pc_plus2_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    if (i_br_taken) begin
      // Bubble a NOP into decode; the old PC tags stay as they were.
      pc_d       = {i_br_target[15:1], 1'b0};
      id_instr_d = 16'h0000;
      id_valid_d = 1'b0;
    end else if (!i_stall) begin
      pc_d          = pc_plus2;
      id_instr_d    = i_imem_instr;
      id_pc_d       = pc_q;
      id_pc_plus2_d = pc_plus2;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q          <= 16'h0000;
      id_instr_q    <= 16'h0000;
      id_pc_q       <= 16'h0000;
      id_pc_plus2_q <= 16'h0000;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus2_q <= id_pc_plus2_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign o_imem_addr   = {pc_q[15:1], 1'b0};
  assign o_id_instr    = id_instr_q;
  assign o_id_pc       = id_pc_q;
  assign o_id_pc_plus2 = id_pc_plus2_q;
  assign o_id_valid    = id_valid_q;
  assign o_fetch_count = fetch_count_q;

endmodule

`default_nettype wire
